hysteresis_threshold: RTL
=========================

# hysteresis_threshold

Streaming double-threshold and single-pass hysteresis stage of the Canny edge pipeline. It sits directly downstream of `gradient_calculation` and consumes its raster-ordered gradient magnitudes. Each magnitude is classified as strong, weak or none. A weak pixel is promoted to an edge when one of its 8 neighbours is strong. Output is one binary edge pixel per input pixel, in raster order.

## Interface
- `IMG_WIDTH`, default 512: pixels per row; must be ≥ 3.
- `IMG_HEIGHT`, default 512: rows per frame; must be ≥ 3.
- `MAG_W`, default 11: magnitude width, matching `gradient_magnitude`.
- `HIGH_TH`, default 200: strong threshold, inclusive.
- `LOW_TH`, default 80: weak threshold, inclusive; `LOW_TH` < `HIGH_TH`.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `mag_in`  in  MAG_W: unsigned gradient magnitude.
- `mag_in_valid`  in  1: a sample is accepted on each rising edge where this is high.
- `edge_pixel_out`  out  8: 8'hFF for an edge, 8'h00 otherwise.
- `edge_pixel_out_valid`  out  1: `edge_pixel_out` is valid this cycle.
- `frame_done`  out  1: one-cycle pulse, coincident with the last output pixel of a frame.

## Operation
- **Classification** (registered on accept), as a 2-bit code:
  - STRONG if `mag_in` ≥ `HIGH_TH`.
  - WEAK if `LOW_TH` ≤ `mag_in` < `HIGH_TH`.
  - NONE otherwise.
  - Comparisons are unsigned and MAG_W wide.
- **Storage:**
  - Two line buffers, IMG_WIDTH × 2 bits each, hold the previous two rows of class codes.
  - A 3×3 class window shifts once per accepted (or flush) sample.
- **Decision for centre pixel (r,c):**
  - STRONG gives 8'hFF.
  - WEAK gives 8'hFF if any in-image neighbour is STRONG in its original class, else 8'h00.
  - NONE gives 8'h00.
  - Promotion does not propagate: a promoted weak pixel does not count as strong for its neighbours.
- **Borders:**
  - Neighbours outside the image count as NONE.
  - Neighbours are masked using the output row/col counters.
  - There is no wrap between column IMG_WIDTH-1 and column 0 of the next row.
  - Stale line-buffer contents are never used, because row-0 top neighbours are masked.
- **State machine:**
  - FILL: accept samples and produce no output until IMG_WIDTH+1 samples have been accepted. Go to STREAM.
  - STREAM: each accept produces one output. After the last input sample (row IMG_HEIGHT-1, col IMG_WIDTH-1) is accepted, go to FLUSH.
  - FLUSH: inject one NONE sample per cycle, with no input required, for IMG_WIDTH+1 cycles. Each cycle produces one output. After the final output go to FILL; counters are cleared.
- **Counters:**
  - Input row/col and output row/col counters wrap at IMG_WIDTH / IMG_HEIGHT.
  - Each frame produces exactly IMG_WIDTH·IMG_HEIGHT outputs.
- **Input during FLUSH:** `mag_in_valid` high during FLUSH is a protocol violation and is ignored. The upstream stage must hold off until FLUSH ends.
- **Reset:**
  - All state returns to FILL and all counters clear.
  - A partial frame is discarded; no further outputs are produced for it.
  - The next accepted sample is pixel (0,0).

## Timing
- **Reset values:** `edge_pixel_out` = 8'h00, `edge_pixel_out_valid` = 0, `frame_done` = 0, state FILL.
- **Latency:**
  - Output for raster index k is registered on the edge after the sample with index k+IMG_WIDTH+1 is accepted.
  - For the last IMG_WIDTH+1 pixels, output is registered on the corresponding FLUSH cycle.
- **Throughput:** one pixel per cycle. Gaps in `mag_in_valid` during FILL/STREAM stall the pipeline without data loss.
- **Output hold:** `edge_pixel_out` holds its last value while valid is low.
- **End of frame:**
  - `frame_done` is asserted together with the output for pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
  - The first sample of the next frame may be accepted on the cycle after `frame_done`.
- **Reset precedence:** reset in the same cycle as a valid input takes precedence; the sample is dropped.

## Test plan
Benches use IMG_WIDTH=8, IMG_HEIGHT=6, HIGH_TH=200, LOW_TH=80.
- **Reset:** hold `rst` for 3 cycles with `mag_in_valid` high → all outputs 0 throughout and 0 afterwards.
- **All-zero frame:**
  - Drive 48 zero samples back-to-back → exactly 48 outputs of 8'h00.
  - First valid output appears one cycle after the 10th accepted sample.
  - `frame_done` pulses with the 48th output; FLUSH lasts 9 cycles.
- **Thresholds:**
  - (2,3)=200 with all others 0 → only output index 19 is 8'hFF.
  - (2,3)=199 with all others 0 → all outputs 8'h00.
  - (2,3)=79 → all outputs 8'h00.
- **Hysteresis:**
  - (2,3)=80 and (3,4)=250 → indices 19 and 28 are 8'hFF.
  - (2,3)=80 and (2,5)=250 → index 19 is 8'h00, index 21 is 8'hFF.
  - Chain (2,1)=90, (2,2)=90, (2,3)=250 → index 17 is 8'h00 (no propagation), index 18 is 8'hFF.
- **Column wrap:** (2,7)=250 and (3,0)=100 → index 24 is 8'h00.
- **Gaps and reset:**
  - Toggle `mag_in_valid` every cycle → output sequence identical to the back-to-back run.
  - Assert `rst` after 20 samples, then send a full frame → exactly 48 outputs, all from the new frame, and one `frame_done`.

Source files
------------

// File: rtl/hysteresis_threshold.sv
// Streaming double-threshold + single-pass hysteresis stage for the Canny edge
// pipeline. Magnitudes are classified into NONE/WEAK/STRONG codes, buffered in
// two class line buffers and a 3x3 class window, and one binary edge pixel is
// produced per input pixel in raster order. A FLUSH phase pushes out the last
// IMG_WIDTH+1 pixels of a frame without needing further input.
module hysteresis_threshold #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int MAG_W      = 11,
  parameter int HIGH_TH    = 200,
  parameter int LOW_TH     = 80
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MAG_W-1:0] mag_in,
  input  logic             mag_in_valid,
  output logic [7:0]       edge_pixel_out,
  output logic             edge_pixel_out_valid,
  output logic             frame_done
);

  localparam logic [1:0] CLS_NONE   = 2'd0;
  localparam logic [1:0] CLS_WEAK   = 2'd1;
  localparam logic [1:0] CLS_STRONG = 2'd2;

  localparam int CIW = $clog2(IMG_WIDTH);      // column index width
  localparam int CW  = $clog2(IMG_WIDTH + 1);  // flush counter reaches IMG_WIDTH
  localparam int RW  = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {FILL = 2'd0, STREAM = 2'd1, FLUSH = 2'd2} state_t;

  state_t state, state_nxt;

  logic [CIW-1:0] in_col;
  logic [RW-1:0]  in_row;
  logic [CW-1:0]  flush_cnt;
  logic [CIW-1:0] out_col;
  logic [RW-1:0]  out_row;

  logic [1:0] lb0 [IMG_WIDTH];   // class codes of the row above the incoming one
  logic [1:0] lb1 [IMG_WIDTH];   // class codes two rows above the incoming one
  logic [1:0] win [3][3];        // [row][col], row 0 = oldest row, col 2 = newest column

  logic       shift;
  logic       calc_nxt;
  logic       calc;
  logic [1:0] cls;
  logic       in_last_col;
  logic       in_last_row;
  logic       out_last_col;
  logic       out_last_row;
  logic       nb_strong;
  logic [7:0] decision;

  function automatic logic [1:0] classify(input logic [MAG_W-1:0] m);
    logic [1:0] c;
    if (m >= MAG_W'(HIGH_TH)) begin
      c = CLS_STRONG;
    end else if (m >= MAG_W'(LOW_TH)) begin
      c = CLS_WEAK;
    end else begin
      c = CLS_NONE;
    end
    return c;
  endfunction

  function automatic logic is_strong(input logic [1:0] c);
    return (c == CLS_STRONG);
  endfunction

  assign in_last_col  = (in_col == CIW'(IMG_WIDTH - 1));
  assign in_last_row  = (in_row == RW'(IMG_HEIGHT - 1));
  assign out_last_col = (out_col == CIW'(IMG_WIDTH - 1));
  assign out_last_row = (out_row == RW'(IMG_HEIGHT - 1));

  // Sequencer: decides when the window shifts, what class enters, and whether an output follows.
  always_comb begin
    state_nxt = state;
    shift     = 1'b0;
    calc_nxt  = 1'b0;
    cls       = CLS_NONE;
    case (state)
      FILL: begin
        if (mag_in_valid) begin
          shift = 1'b1;
          cls   = classify(mag_in);
          // The (IMG_WIDTH+1)-th sample of the frame is pixel (1,0).
          if ((in_row == RW'(1)) && (in_col == CIW'(0))) begin
            state_nxt = STREAM;
          end else begin
            state_nxt = FILL;
          end
        end else begin
          state_nxt = FILL;
        end
      end
      STREAM: begin
        if (mag_in_valid) begin
          shift    = 1'b1;
          calc_nxt = 1'b1;
          cls      = classify(mag_in);
          if (in_last_col && in_last_row) begin
            state_nxt = FLUSH;
          end else begin
            state_nxt = STREAM;
          end
        end else begin
          state_nxt = STREAM;
        end
      end
      FLUSH: begin
        // Input is ignored here; NONE samples pad below and right of the image.
        shift    = 1'b1;
        calc_nxt = 1'b1;
        cls      = CLS_NONE;
        if (flush_cnt == CW'(IMG_WIDTH)) begin
          state_nxt = FILL;
        end else begin
          state_nxt = FLUSH;
        end
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Input-side position counters; in_col keeps counting through FLUSH as the line-buffer address.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_col    <= '0;
      in_row    <= '0;
      flush_cnt <= '0;
    end else if (shift) begin
      if (state == FLUSH) begin
        if (flush_cnt == CW'(IMG_WIDTH)) begin
          flush_cnt <= '0;
          in_col    <= '0;
          in_row    <= '0;
        end else begin
          flush_cnt <= flush_cnt + CW'(1);
          in_col    <= in_last_col ? '0 : in_col + CIW'(1);
        end
      end else begin
        flush_cnt <= '0;
        if (in_last_col) begin
          in_col <= '0;
          in_row <= in_last_row ? '0 : in_row + RW'(1);
        end else begin
          in_col <= in_col + CIW'(1);
        end
      end
    end
  end

  // Line buffers: each column slot ages one row per write; contents need no reset since borders are masked.
  always_ff @(posedge clk) begin
    if (shift) begin
      lb1[in_col] <= lb0[in_col];
      lb0[in_col] <= cls;
    end
  end

  // 3x3 class window: shift left and load the new column from the line buffers and the fresh class.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= CLS_NONE;
        end
      end
    end else if (shift) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb1[in_col];
      win[1][2] <= lb0[in_col];
      win[2][2] <= cls;
    end
  end

  // Edge decision for the window centre, masking neighbours that fall outside the image.
  always_comb begin
    nb_strong =
        ((out_row != '0) && (out_col != '0) && is_strong(win[0][0])) ||
        ((out_row != '0)                     && is_strong(win[0][1])) ||
        ((out_row != '0) && !out_last_col    && is_strong(win[0][2])) ||
        ((out_col != '0)                     && is_strong(win[1][0])) ||
        (!out_last_col                       && is_strong(win[1][2])) ||
        (!out_last_row && (out_col != '0)    && is_strong(win[2][0])) ||
        (!out_last_row                       && is_strong(win[2][1])) ||
        (!out_last_row && !out_last_col      && is_strong(win[2][2]));
    if (win[1][1] == CLS_STRONG) begin
      decision = 8'hFF;
    end else if ((win[1][1] == CLS_WEAK) && nb_strong) begin
      decision = 8'hFF;
    end else begin
      decision = 8'h00;
    end
  end

  // Output stage: registers the decision one edge after the shift and tracks the output position.
  always_ff @(posedge clk) begin
    if (rst) begin
      calc                 <= 1'b0;
      edge_pixel_out       <= 8'h00;
      edge_pixel_out_valid <= 1'b0;
      frame_done           <= 1'b0;
      out_col              <= '0;
      out_row              <= '0;
    end else begin
      calc <= calc_nxt;
      if (calc) begin
        edge_pixel_out       <= decision;
        edge_pixel_out_valid <= 1'b1;
        frame_done           <= out_last_col && out_last_row;
        if (out_last_col) begin
          out_col <= '0;
          out_row <= out_last_row ? '0 : out_row + RW'(1);
        end else begin
          out_col <= out_col + CIW'(1);
        end
      end else begin
        edge_pixel_out_valid <= 1'b0;
        frame_done           <= 1'b0;
      end
    end
  end

endmodule
